// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle between decode, hazard unit, downstream stages and the ID/EX pipeline register
//   in_*            decoded instruction presented by decode
//   stall, flush    hazard unit controls
//   exmem_*, memwb_* downstream write-back candidates for forwarding
//   OPCODE, a, b    forwarded operands and opcode to the ALU
//   out_rd_addr, out_wen, out_valid  latched destination, qualified write enable, slot valid
interface id_ex_stage_if #(
  parameter int N  = 16,
  parameter int AW = 3
);
  logic          in_valid;
  logic [2:0]    in_opcode;
  logic [N-1:0]  in_rs_data;
  logic [N-1:0]  in_rt_data;
  logic [AW-1:0] in_rs_addr;
  logic [AW-1:0] in_rt_addr;
  logic [AW-1:0] in_rd_addr;
  logic          in_wen;
  logic          stall;
  logic          flush;
  logic          exmem_wen;
  logic          memwb_wen;
  logic [AW-1:0] exmem_addr;
  logic [AW-1:0] memwb_addr;
  logic [N-1:0]  exmem_data;
  logic [N-1:0]  memwb_data;
  logic [2:0]    OPCODE;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [AW-1:0] out_rd_addr;
  logic          out_wen;
  logic          out_valid;

  modport master (
    output in_valid, in_opcode, in_rs_data, in_rt_data, in_rs_addr, in_rt_addr, in_rd_addr, in_wen,
    output stall, flush, exmem_wen, memwb_wen, exmem_addr, memwb_addr, exmem_data, memwb_data,
    input  OPCODE, a, b, out_rd_addr, out_wen, out_valid
  );

  modport slave (
    input  in_valid, in_opcode, in_rs_data, in_rt_data, in_rs_addr, in_rt_addr, in_rd_addr, in_wen,
    input  stall, flush, exmem_wen, memwb_wen, exmem_addr, memwb_addr, exmem_data, memwb_data,
    output OPCODE, a, b, out_rd_addr, out_wen, out_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears the whole slot
//   bus    id_ex_stage_if slave: decode inputs, hazard controls, forwarding sources, ALU-facing outputs
module id_ex_stage #(
  parameter int N  = 16,
  parameter int AW = 3
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  logic [2:0]    opcodeQ;
  logic [N-1:0]  rsDataQ;
  logic [N-1:0]  rtDataQ;
  logic [AW-1:0] rsAddrQ;
  logic [AW-1:0] rtAddrQ;
  logic [AW-1:0] rdAddrQ;
  logic          wenQ;
  logic          validQ;
  logic [N-1:0]  fwdA;
  logic [N-1:0]  fwdB;
  // EX/MEM is checked first so the youngest producer wins; r0 and bubbles never forward
  always_comb begin
    fwdA = (validQ && rsAddrQ != '0 && bus.exmem_wen && bus.exmem_addr == rsAddrQ) ? bus.exmem_data :
           (validQ && rsAddrQ != '0 && bus.memwb_wen && bus.memwb_addr == rsAddrQ) ? bus.memwb_data : rsDataQ;
    fwdB = (validQ && rtAddrQ != '0 && bus.exmem_wen && bus.exmem_addr == rtAddrQ) ? bus.exmem_data :
           (validQ && rtAddrQ != '0 && bus.memwb_wen && bus.memwb_addr == rtAddrQ) ? bus.memwb_data : rtDataQ;
  end
  // While stalled the operand registers re-capture the forwarded values so a
  // producer retiring during the stall does not take its result with it
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      opcodeQ <= '0;
      rsDataQ <= '0;
      rtDataQ <= '0;
      rsAddrQ <= '0;
      rtAddrQ <= '0;
      rdAddrQ <= '0;
      wenQ    <= 1'b0;
      validQ  <= 1'b0;
    end else if (bus.stall) begin
      rsDataQ <= fwdA;
      rtDataQ <= fwdB;
    end else begin
      opcodeQ <= bus.in_opcode;
      rsDataQ <= bus.in_rs_data;
      rtDataQ <= bus.in_rt_data;
      rsAddrQ <= bus.in_rs_addr;
      rtAddrQ <= bus.in_rt_addr;
      rdAddrQ <= bus.in_rd_addr;
      wenQ    <= bus.in_wen;
      validQ  <= bus.in_valid;
    end
  end
  assign bus.OPCODE      = opcodeQ;
  assign bus.a           = fwdA;
  assign bus.b           = fwdB;
  assign bus.out_rd_addr = rdAddrQ;
  assign bus.out_wen     = wenQ & validQ;
  assign bus.out_valid   = validQ;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  id_ex_stage_if #(.N(16), .AW(3)) bus ();
  id_ex_stage #(.N(16), .AW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] rsd, input logic [15:0] rtd,
                       input logic [2:0] rsa, input logic [2:0] rta, input logic [2:0] rda, input logic w);
    bus.in_valid = v;
    bus.in_opcode = op;
    bus.in_rs_data = rsd;
    bus.in_rt_data = rtd;
    bus.in_rs_addr = rsa;
    bus.in_rt_addr = rta;
    bus.in_rd_addr = rda;
    bus.in_wen = w;
  endtask

  task automatic fwd_off();
    bus.exmem_wen = 0; bus.exmem_addr = 0; bus.exmem_data = 0;
    bus.memwb_wen = 0; bus.memwb_addr = 0; bus.memwb_data = 0;
  endtask

  task automatic test_reset();
    bus.stall = 0; bus.flush = 0;
    fwd_off();
    drive(1, 3'd7, 16'hDEAD, 16'hBEEF, 3'd1, 3'd2, 3'd3, 1);
    rst_n = 0;
    tick(); tick();
    checks++; if (bus.OPCODE !== 3'd0) begin failures++; $display("FAIL reset_opcode got=%h exp=0", bus.OPCODE); end
    checks++; if (bus.a !== 16'h0) begin failures++; $display("FAIL reset_a got=%h exp=0", bus.a); end
    checks++; if (bus.b !== 16'h0) begin failures++; $display("FAIL reset_b got=%h exp=0", bus.b); end
    checks++; if (bus.out_rd_addr !== 3'd0) begin failures++; $display("FAIL reset_rd got=%h exp=0", bus.out_rd_addr); end
    checks++; if (bus.out_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.out_wen); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    rst_n = 1;
  endtask

  task automatic test_load();
    drive(1, 3'b010, 16'h0005, 16'h0003, 3'd1, 3'd2, 3'd4, 1);
    tick();
    checks++; if (bus.OPCODE !== 3'd2) begin failures++; $display("FAIL load_opcode got=%h exp=2", bus.OPCODE); end
    checks++; if (bus.a !== 16'h0005) begin failures++; $display("FAIL load_a got=%h exp=0005", bus.a); end
    checks++; if (bus.b !== 16'h0003) begin failures++; $display("FAIL load_b got=%h exp=0003", bus.b); end
    checks++; if (bus.out_rd_addr !== 3'd4) begin failures++; $display("FAIL load_rd got=%h exp=4", bus.out_rd_addr); end
    checks++; if (bus.out_wen !== 1'b1) begin failures++; $display("FAIL load_wen got=%b exp=1", bus.out_wen); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL load_valid got=%b exp=1", bus.out_valid); end
  endtask

  task automatic test_forward();
    drive(1, 3'd1, 16'h0011, 16'h0022, 3'd2, 3'd5, 3'd6, 1);
    tick();
    bus.exmem_wen = 1; bus.exmem_addr = 3'd2; bus.exmem_data = 16'hAAAA;
    bus.memwb_wen = 1; bus.memwb_addr = 3'd2; bus.memwb_data = 16'h5555;
    #1;
    checks++; if (bus.a !== 16'hAAAA) begin failures++; $display("FAIL fwd_exmem_a got=%h exp=AAAA", bus.a); end
    checks++; if (bus.b !== 16'h0022) begin failures++; $display("FAIL fwd_nomatch_b got=%h exp=0022", bus.b); end
    bus.exmem_wen = 0;
    #1;
    checks++; if (bus.a !== 16'h5555) begin failures++; $display("FAIL fwd_memwb_a got=%h exp=5555", bus.a); end
    bus.memwb_wen = 0;
    #1;
    checks++; if (bus.a !== 16'h0011) begin failures++; $display("FAIL fwd_none_a got=%h exp=0011", bus.a); end
    bus.exmem_wen = 1; bus.exmem_addr = 3'd5; bus.exmem_data = 16'hC0DE;
    #1;
    checks++; if (bus.b !== 16'hC0DE) begin failures++; $display("FAIL fwd_exmem_b got=%h exp=C0DE", bus.b); end
    drive(0, 3'd6, 16'h0033, 16'h0044, 3'd5, 3'd5, 3'd7, 1);
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_wen !== 1'b0) begin failures++; $display("FAIL bubble_wen got=%b exp=0", bus.out_wen); end
    checks++; if (bus.OPCODE !== 3'd6) begin failures++; $display("FAIL bubble_opcode got=%h exp=6", bus.OPCODE); end
    checks++; if (bus.out_rd_addr !== 3'd7) begin failures++; $display("FAIL bubble_rd got=%h exp=7", bus.out_rd_addr); end
    checks++; if (bus.a !== 16'h0033) begin failures++; $display("FAIL bubble_nofwd_a got=%h exp=0033", bus.a); end
    checks++; if (bus.b !== 16'h0044) begin failures++; $display("FAIL bubble_nofwd_b got=%h exp=0044", bus.b); end
    fwd_off();
  endtask

  task automatic test_r0();
    drive(1, 3'd3, 16'h0000, 16'h0007, 3'd0, 3'd0, 3'd1, 1);
    tick();
    bus.exmem_wen = 1; bus.exmem_addr = 3'd0; bus.exmem_data = 16'hFFFF;
    bus.memwb_wen = 1; bus.memwb_addr = 3'd0; bus.memwb_data = 16'hEEEE;
    #1;
    checks++; if (bus.a !== 16'h0000) begin failures++; $display("FAIL r0_a got=%h exp=0000", bus.a); end
    checks++; if (bus.b !== 16'h0007) begin failures++; $display("FAIL r0_b got=%h exp=0007", bus.b); end
    fwd_off();
  endtask

  task automatic test_stall_capture();
    drive(1, 3'd5, 16'h0001, 16'h0009, 3'd4, 3'd3, 3'd6, 1);
    tick();
    bus.memwb_wen = 1; bus.memwb_addr = 3'd3; bus.memwb_data = 16'h1234;
    #1;
    checks++; if (bus.b !== 16'h1234) begin failures++; $display("FAIL stall_pre_b got=%h exp=1234", bus.b); end
    bus.stall = 1;
    drive(1, 3'd1, 16'hAAAA, 16'hBBBB, 3'd1, 3'd1, 3'd2, 0);
    tick();
    bus.memwb_wen = 0; bus.memwb_data = 16'h0000;
    #1;
    checks++; if (bus.b !== 16'h1234) begin failures++; $display("FAIL stall_hold_b got=%h exp=1234", bus.b); end
    checks++; if (bus.a !== 16'h0001) begin failures++; $display("FAIL stall_hold_a got=%h exp=0001", bus.a); end
    checks++; if (bus.OPCODE !== 3'd5) begin failures++; $display("FAIL stall_opcode got=%h exp=5", bus.OPCODE); end
    checks++; if (bus.out_rd_addr !== 3'd6) begin failures++; $display("FAIL stall_rd got=%h exp=6", bus.out_rd_addr); end
    checks++; if (bus.out_wen !== 1'b1) begin failures++; $display("FAIL stall_wen got=%b exp=1", bus.out_wen); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", bus.out_valid); end
    bus.stall = 0;
    fwd_off();
  endtask

  task automatic test_flush_stall();
    drive(1, 3'd4, 16'h0101, 16'h0202, 3'd1, 3'd2, 3'd3, 1);
    tick();
    drive(1, 3'd7, 16'h0303, 16'h0404, 3'd4, 3'd5, 3'd6, 1);
    bus.flush = 1; bus.stall = 1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_wen !== 1'b0) begin failures++; $display("FAIL flush_wen got=%b exp=0", bus.out_wen); end
    checks++; if (bus.OPCODE !== 3'd0) begin failures++; $display("FAIL flush_opcode got=%h exp=0", bus.OPCODE); end
    checks++; if (bus.a !== 16'h0) begin failures++; $display("FAIL flush_a got=%h exp=0", bus.a); end
    checks++; if (bus.b !== 16'h0) begin failures++; $display("FAIL flush_b got=%h exp=0", bus.b); end
    checks++; if (bus.out_rd_addr !== 3'd0) begin failures++; $display("FAIL flush_rd got=%h exp=0", bus.out_rd_addr); end
    bus.flush = 0; bus.stall = 0;
  endtask

  task automatic test_reset_mid();
    drive(1, 3'd6, 16'h7777, 16'h8888, 3'd1, 3'd2, 3'd5, 1);
    tick();
    bus.stall = 1;
    tick();
    rst_n = 0;
    tick();
    checks++; if (bus.OPCODE !== 3'd0) begin failures++; $display("FAIL rstmid_opcode got=%h exp=0", bus.OPCODE); end
    checks++; if (bus.a !== 16'h0) begin failures++; $display("FAIL rstmid_a got=%h exp=0", bus.a); end
    checks++; if (bus.b !== 16'h0) begin failures++; $display("FAIL rstmid_b got=%h exp=0", bus.b); end
    checks++; if (bus.out_rd_addr !== 3'd0) begin failures++; $display("FAIL rstmid_rd got=%h exp=0", bus.out_rd_addr); end
    checks++; if (bus.out_wen !== 1'b0) begin failures++; $display("FAIL rstmid_wen got=%b exp=0", bus.out_wen); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
    rst_n = 1; bus.stall = 0;
  endtask

  task automatic test_sweep();
    logic [15:0] vals [8];
    vals = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'hAAAA, 16'h5555, 16'h1234};
    fwd_off();
    for (int op = 0; op < 8; op++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          drive(1, 3'(op), vals[i], vals[j], 3'(i), 3'(j), 3'(op), 1);
          tick();
          checks++; if (bus.OPCODE !== 3'(op)) begin failures++; $display("FAIL sweep_opcode op=%0d i=%0d j=%0d got=%h exp=%h", op, i, j, bus.OPCODE, 3'(op)); end
          checks++; if (bus.a !== vals[i]) begin failures++; $display("FAIL sweep_a op=%0d i=%0d j=%0d got=%h exp=%h", op, i, j, bus.a, vals[i]); end
          checks++; if (bus.b !== vals[j]) begin failures++; $display("FAIL sweep_b op=%0d i=%0d j=%0d got=%h exp=%h", op, i, j, bus.b, vals[j]); end
        end
  endtask

  initial begin
    test_reset();
    test_load();
    test_forward();
    test_r0();
    test_stall_capture();
    test_flush_stall();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N, default 16, datapath width matching the ALU operand width.
REQ-002 SHALL have parameter AW, default 3, register-address width (8 registers, r0 reads as zero).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 in_valid  input  1  decode stage presents a valid instruction.
REQ-006 in_opcode  input  3  ALU operation code from decode.
REQ-007 in_rs_data, in_rt_data  input  N  register-file read data for operand a / b.
REQ-008 in_rs_addr, in_rt_addr, in_rd_addr  input  AW  source and destination register numbers.
REQ-009 in_wen  input  1  instruction writes rd.
REQ-010 stall  input  1  hazard unit holds this stage.
REQ-011 flush  input  1  hazard unit kills the instruction being loaded.
REQ-012 exmem_wen, memwb_wen  input  1  downstream stage will write its destination.
REQ-013 exmem_addr, memwb_addr  input  AW  downstream destination register numbers.
REQ-014 exmem_data, memwb_data  input  N  downstream result values.
REQ-015 OPCODE  output  3  opcode to ALU.
REQ-016 a, b  output  N  forwarded operands to ALU.
REQ-017 out_rd_addr  output  AW  latched destination register.
REQ-018 out_wen  output  1  latched write enable, forced 0 when out_valid=0.
REQ-019 out_valid  output  1  stage holds a live instruction.

Function
REQ-020 SHALL hold one pipeline slot: opcode, rs/rt data, rs/rt/rd addresses, wen, valid registers.
REQ-021 Per-edge priority SHALL be: reset > flush > stall > load.
REQ-022 Load (no flush, no stall): all registers capture in_* on the edge; latency exactly 1 cycle.
REQ-023 Flush: out_valid=0, out_wen=0, opcode/data/addresses cleared to 0 (bubble); flush with stall still flushes.
REQ-024 Stall: opcode, addresses, wen, valid hold; rs/rt data registers capture current forwarded a/b so a forwarded value is not lost when its producer retires.
REQ-025 Forwarding (combinational on a): if out_valid and rs_addr!=0 and exmem_wen and exmem_addr==rs_addr -> exmem_data; else if out_valid and rs_addr!=0 and memwb_wen and memwb_addr==rs_addr -> memwb_data; else latched rs data.
REQ-026 Forwarding for b SHALL be identical using rt_addr and rt data.
REQ-027 EX/MEM SHALL take priority over MEM/WB when both match (youngest value wins).
REQ-028 Register 0 SHALL never be forwarded; a source address of 0 yields latched data.
REQ-029 When out_valid=0, a and b SHALL drive latched data without forwarding.
REQ-030 OPCODE, out_rd_addr SHALL be direct register outputs; out_wen = wen_q AND out_valid.
REQ-031 No arithmetic is performed; widths pass through unchanged, no truncation or extension.
REQ-032 in_valid=0 on a load edge SHALL load a bubble (out_valid=0, out_wen=0), other fields captured as presented.

Reset
REQ-033 rst_n=0 at a rising edge SHALL clear every register to 0: OPCODE=0, a=b=0, out_rd_addr=0, out_wen=0, out_valid=0.
REQ-034 Reset SHALL override stall and flush and discard an in-flight instruction mid-operation.
REQ-035 Outputs before the first reset edge are undefined; bench SHALL apply reset at least 1 cycle first.

Verification
REQ-036 Load: in_valid=1, opcode=3'b010, rs_data=16'h0005, rt_data=16'h0003, rd=4, wen=1 -> next cycle OPCODE=2, a=5, b=3, out_rd_addr=4, out_wen=1, out_valid=1.
REQ-037 Forward priority: latched rs=2, exmem(wen=1,addr=2,data=16'hAAAA), memwb(wen=1,addr=2,data=16'h5555) -> a=16'hAAAA; drop exmem_wen -> a=16'h5555; both off -> a=latched data.
REQ-038 r0 guard: rs_addr=0, latched data 0, exmem(wen=1,addr=0,data=16'hFFFF) -> a=0.
REQ-039 Stall capture: latched rt=3, memwb forwards 16'h1234 to b, stall=1 one cycle while memwb_wen then drops -> b stays 16'h1234; other outputs unchanged.
REQ-040 Flush+stall same edge with valid instruction in -> out_valid=0, out_wen=0, OPCODE=0, a=b=0.
REQ-041 Reset mid-stream: valid instruction held under stall, rst_n=0 one edge -> all outputs 0 next cycle; sweep all 8 opcodes x 8x8 operand values through loads and check ALU inputs match.
